// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//
// Purpose:
//   Front end for a quadrature encoder that feeds the up/down counter. The two
//   raw encoder channels are synchronised, debounced, and decoded as a Gray
//   code. Each accepted legal edge produces one single-cycle control pulse
//   (x4 counting). An edge where both channels change at once is illegal. It
//   raises err for one cycle and bumps a saturating error counter, and it
//   does not produce a pulse.
//
// Ports:
//   clk        in   single clock, all state updates on its rising edge
//   rst        in   synchronous, active-high reset
//   enc_a      in   raw encoder channel A (asynchronous to clk)
//   enc_b      in   raw encoder channel B (asynchronous to clk)
//   enable     in   low forces control to 00; tracking keeps running
//   control    out  [1:0] 01 = INC, 10 = DEC, 00 = hold (registered pulse)
//   err        out  one-cycle pulse on an illegal transition
//   err_count  out  [7:0] illegal transition count, saturates at 255
//
// Parameters:
//   DEB_CYCLES  consecutive differing samples needed to accept a change
//               (1 .. 2^DEB_W-1)
//   DEB_W       width of each channel's debounce counter
// -----------------------------------------------------------------------------
module quad_decoder #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enable,
  output logic [1:0] control,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_ZERO  = '0;
  localparam logic [1:0]       INIT_LAST = 2'd2;
  localparam logic [1:0]       CTRL_HOLD = 2'b00;
  localparam logic [1:0]       CTRL_INC  = 2'b01;
  localparam logic [1:0]       CTRL_DEC  = 2'b10;
  localparam logic [7:0]       ERR_MAX   = 8'd255;

  typedef enum logic {
    StInit,
    StRun
  } stateType;

  logic             metaA_q, metaB_q;
  logic             syncA_q, syncB_q;
  logic             stableA_q, stableA_d;
  logic             stableB_q, stableB_d;
  logic [DEB_W-1:0] cntA_q, cntA_d;
  logic [DEB_W-1:0] cntB_q, cntB_d;
  logic [1:0]       prev_q, prev_d;
  stateType         state_q, state_d;
  logic [1:0]       initCnt_q, initCnt_d;
  logic [1:0]       control_q, control_d;
  logic             err_q, err_d;
  logic [7:0]       errCount_q, errCount_d;

  logic [1:0]       curAB;
  logic [1:0]       decCode;
  logic             illegal;

  // Successor of a {A,B} code when turning forward: 00 -> 01 -> 11 -> 10 -> 00.
  // A single-bit change that does not land on this successor is a reverse step.
  function automatic logic [1:0] fwdNext(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Decode the step from the previously seen debounced code to the current one.
  // No change means hold. A change in both bits is illegal because the
  // direction cannot be known. Otherwise the step is compared with the
  // forward successor to pick INC or DEC.
  always_comb begin
    curAB   = {stableA_q, stableB_q};
    decCode = CTRL_HOLD;
    illegal = 1'b0;
    if ((prev_q ^ curAB) == 2'b11) begin
      illegal = 1'b1;
    end else if (prev_q != curAB) begin
      if (curAB == fwdNext(prev_q)) begin
        decCode = CTRL_INC;
      end else begin
        decCode = CTRL_DEC;
      end
    end
  end

  // Per-channel debouncers. A new level is accepted only after DEB_CYCLES
  // consecutive samples that differ from the accepted level. Any matching
  // sample in between restarts the count, so short glitches never reach the
  // decoder. During INIT the accepted levels track the synchronisers
  // directly. This lets an encoder parked on any detent come up silently.
  always_comb begin
    stableA_d = stableA_q;
    stableB_d = stableB_q;
    cntA_d    = cntA_q;
    cntB_d    = cntB_q;

    if (state_q == StInit) begin
      stableA_d = syncA_q;
      stableB_d = syncB_q;
      cntA_d    = DEB_ZERO;
      cntB_d    = DEB_ZERO;
    end else begin
      if (syncA_q == stableA_q) begin
        cntA_d = DEB_ZERO;
      end else if (cntA_q == DEB_LAST) begin
        stableA_d = syncA_q;
        cntA_d    = DEB_ZERO;
      end else begin
        cntA_d = cntA_q + DEB_ONE;
      end

      if (syncB_q == stableB_q) begin
        cntB_d = DEB_ZERO;
      end else if (cntB_q == DEB_LAST) begin
        stableB_d = syncB_q;
        cntB_d    = DEB_ZERO;
      end else begin
        cntB_d = cntB_q + DEB_ONE;
      end
    end
  end

  // Control FSM. INIT lasts three cycles after reset. That is long enough for
  // the two synchroniser stages and the debounced levels to settle on the real
  // encoder position, and no pulse is produced in that time. RUN registers one
  // decode per cycle. The enable input only masks control, so prev, err and
  // err_count keep advancing, and turning enable back on cannot replay an old
  // step.
  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    prev_d     = prev_q;
    control_d  = CTRL_HOLD;
    err_d      = 1'b0;
    errCount_d = errCount_q;

    case (state_q)
      StInit: begin
        prev_d = {syncA_q, syncB_q};
        if (initCnt_q == INIT_LAST) begin
          state_d   = StRun;
          initCnt_d = 2'd0;
        end else begin
          initCnt_d = initCnt_q + 2'd1;
        end
      end
      StRun: begin
        prev_d    = curAB;
        control_d = enable ? decCode : CTRL_HOLD;
        if (illegal) begin
          err_d = 1'b1;
          if (errCount_q != ERR_MAX) begin
            errCount_d = errCount_q + 8'd1;
          end
        end
      end
      default: begin
        state_d   = StInit;
        initCnt_d = 2'd0;
      end
    endcase
  end

  // All state registers, including the two-flop synchronisers. A synchronous
  // reset returns everything to INIT and discards any debounce progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      metaA_q    <= 1'b0;
      metaB_q    <= 1'b0;
      syncA_q    <= 1'b0;
      syncB_q    <= 1'b0;
      stableA_q  <= 1'b0;
      stableB_q  <= 1'b0;
      cntA_q     <= DEB_ZERO;
      cntB_q     <= DEB_ZERO;
      prev_q     <= 2'b00;
      state_q    <= StInit;
      initCnt_q  <= 2'd0;
      control_q  <= CTRL_HOLD;
      err_q      <= 1'b0;
      errCount_q <= 8'd0;
    end else begin
      metaA_q    <= enc_a;
      metaB_q    <= enc_b;
      syncA_q    <= metaA_q;
      syncB_q    <= metaB_q;
      stableA_q  <= stableA_d;
      stableB_q  <= stableB_d;
      cntA_q     <= cntA_d;
      cntB_q     <= cntB_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      initCnt_q  <= initCnt_d;
      control_q  <= control_d;
      err_q      <= err_d;
      errCount_q <= errCount_d;
    end
  end

  assign control   = control_q;
  assign err       = err_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
//
// Purpose:
//   Self-checking bench for quad_decoder with DEB_CYCLES = 4. Each encoder
//   step is driven just after a rising edge. When a step is driven, the pulse
//   it must cause is pushed to a scoreboard. That pulse is due seven edges
//   later: two synchroniser edges, four debounce edges and one decode edge.
//   A monitor on the falling edge compares control, err and err_count on
//   every cycle. In cycles with no scheduled event it expects 00 / 0.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int LATENCY = 7;

  typedef struct {
    logic       rstFirst;
    logic       a;
    logic       b;
    logic       en;
    int         hold;
    logic [1:0] ctrl;
    logic       err;
  } vecType;

  typedef struct {
    int         cyc;
    logic [1:0] ctrl;
    logic       err;
  } evType;

  logic       clk;
  logic       rst;
  logic       encA;
  logic       encB;
  logic       enable;
  logic [1:0] control;
  logic       err;
  logic [7:0] errCount;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       checkEn = 1'b0;
  logic [7:0] expErrCnt = 8'd0;
  logic [7:0] dsCount = 8'd0;
  logic [7:0] dsBase;
  evType      sbq[$];
  vecType     vecs[26];

  logic [1:0] monCtrl;
  logic       monErr;
  evType      monEv;

  quad_decoder #(
    .DEB_CYCLES(4),
    .DEB_W     (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enc_a    (encA),
    .enc_b    (encB),
    .enable   (enable),
    .control  (control),
    .err      (err),
    .err_count(errCount)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so scoreboard events can be scheduled by edge number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Falling-edge monitor. A scoreboard event due this cycle supplies the
  // expected control and err values. Otherwise hold is expected. It also keeps
  // a model of the downstream counter, driven by the DUT's pulses.
  always @(negedge clk) begin
    if (checkEn) begin
      monCtrl = 2'b00;
      monErr  = 1'b0;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        monEv   = sbq.pop_front();
        monCtrl = monEv.ctrl;
        monErr  = monEv.err;
        if (monEv.err && expErrCnt != 8'd255) begin
          expErrCnt = expErrCnt + 8'd1;
        end
      end
      checkOutput("control", {6'b0, control}, {6'b0, monCtrl});
      checkOutput("err", {7'b0, err}, {7'b0, monErr});
      checkOutput("err_count", errCount, expErrCnt);
    end
    if (control == 2'b01) begin
      dsCount = dsCount + 8'd1;
    end else if (control == 2'b10) begin
      dsCount = dsCount - 8'd1;
    end
  end

  // Advance n rising edges and settle just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new encoder position and schedule the event it must produce.
  task automatic driveStep(input logic a, input logic b, input logic [1:0] ctrl, input logic e);
    evType ev;
    encA = a;
    encB = b;
    if (ctrl != 2'b00 || e) begin
      ev.cyc  = cyc + LATENCY;
      ev.ctrl = ctrl;
      ev.err  = e;
      sbq.push_back(ev);
    end
  endtask

  // Hold reset for three edges with the encoder parked at {a,b}, check the
  // reset values, then release reset.
  task automatic doReset(input logic a, input logic b);
    checkEn = 1'b0;
    encA    = a;
    encB    = b;
    rst     = 1'b1;
    waitCycles(3);
    checkOutput("reset control", {6'b0, control}, 8'h00);
    checkOutput("reset err", {7'b0, err}, 8'h00);
    checkOutput("reset err_count", errCount, 8'h00);
    sbq.delete();
    expErrCnt = 8'd0;
    rst       = 1'b0;
    checkEn   = 1'b1;
  endtask

  // Apply a range of the vector table in order.
  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      enable = vecs[i].en;
      if (vecs[i].rstFirst) begin
        doReset(vecs[i].a, vecs[i].b);
      end else begin
        driveStep(vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].err);
      end
      waitCycles(vecs[i].hold);
    end
  endtask

  initial begin
    // Fields: rstFirst, a, b, en, hold, expected control, expected err.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 50, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1,  5, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 2'b01, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 2'b01, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10, 2'b01, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 2'b01, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1,  5, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10, 2'b10, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 2'b10, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 2'b10, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 2'b10, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1,  5, 2'b00, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1,  3, 2'b00, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 2'b00, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1,  1, 2'b00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 2'b00, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1,  2, 2'b00, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 2'b00, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1,  3, 2'b00, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 2'b00, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1,  4, 2'b01, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 12, 2'b10, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 2'b00, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 2'b00, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 2'b00, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 2'b01, 1'b0};

    rst    = 1'b1;
    encA   = 1'b0;
    encB   = 1'b0;
    enable = 1'b1;

    $display("[TB] reset at detent 11, then 50 idle cycles");
    applyStimulus(0, 0);

    $display("[TB] forward rotation");
    applyStimulus(1, 1);
    dsBase = dsCount;
    applyStimulus(2, 5);
    checkOutput("downstream after forward", dsCount - dsBase, 8'd4);

    $display("[TB] reverse rotation");
    applyStimulus(6, 6);
    dsBase = dsCount;
    applyStimulus(7, 10);
    checkOutput("downstream after reverse", dsCount - dsBase, 8'd252);

    $display("[TB] glitch rejection");
    applyStimulus(11, 21);

    $display("[TB] illegal transitions and err_count saturation");
    doReset(1'b0, 1'b0);
    waitCycles(5);
    for (int i = 0; i < 300; i++) begin
      driveStep(!encA, !encB, 2'b00, 1'b1);
      waitCycles(6);
    end
    waitCycles(4);
    checkOutput("err_count saturated", errCount, 8'd255);

    $display("[TB] enable masking");
    applyStimulus(22, 25);

    $display("[TB] mid-debounce reset");
    driveStep(1'b0, 1'b1, 2'b00, 1'b0);
    waitCycles(4);
    checkEn = 1'b0;
    rst     = 1'b1;
    waitCycles(2);
    checkOutput("mid reset control", {6'b0, control}, 8'h00);
    checkOutput("mid reset err", {7'b0, err}, 8'h00);
    checkOutput("mid reset err_count", errCount, 8'h00);
    sbq.delete();
    expErrCnt = 8'd0;
    rst       = 1'b0;
    checkEn   = 1'b1;
    waitCycles(30);

    checkOutput("scoreboard drained", 8'(sbq.size()), 8'd0);
    checkEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
